// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED controller shift/latch path:
// channel limit, counter-width helper and shift-direction constants.
package led_ctrl_pkg;

    // Widest frame the LED controller supports.
    localparam int LED_MAX_WIDTH = 32;

    // Shift-direction selectors for the MSB_FIRST parameter.
    localparam int SHIFT_MSB_FIRST = 1;
    localparam int SHIFT_LSB_FIRST = 0;

    // Counter width able to hold 0..width inclusive.
    function automatic int clog2_p1(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/led_shift_latch_sync2.sv
// sync2: single-bit two-flop synchronizer, asynchronous active-high reset,
// both flops reset to 0.
module sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops to resolve metastability of an asynchronous input.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/led_shift_latch.sv
// led_shift_latch: serial-in shift register with bit counter, output latch,
// daisy-chain SDO and sticky short-frame error.
// Optional macro LED_SHIFT_LATCH_SYNC_EN: SDI, SHIFT, LATCH and CLR_ERR pass
// through two-flop synchronizers (adds 2 cycles of input latency).
module led_shift_latch
    import led_ctrl_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = SHIFT_MSB_FIRST
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SDI,
    input  logic             SHIFT,
    input  logic             LATCH,
    input  logic             CLR_ERR,
    output logic [WIDTH-1:0] Q,
    output logic             SDO,
    output logic             READY,
    output logic             ERR
);

    localparam int CW = clog2_p1(WIDTH);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    logic w_sdi;
    logic w_shift;
    logic w_latch;
    logic w_clr_err;

`ifdef LED_SHIFT_LATCH_SYNC_EN
    sync2 u_sync_sdi   (.i_clk(CLK), .i_rst(RST), .i_d(SDI),     .o_q(w_sdi));
    sync2 u_sync_shift (.i_clk(CLK), .i_rst(RST), .i_d(SHIFT),   .o_q(w_shift));
    sync2 u_sync_latch (.i_clk(CLK), .i_rst(RST), .i_d(LATCH),   .o_q(w_latch));
    sync2 u_sync_clr   (.i_clk(CLK), .i_rst(RST), .i_d(CLR_ERR), .o_q(w_clr_err));
`else
    assign w_sdi     = SDI;
    assign w_shift   = SHIFT;
    assign w_latch   = LATCH;
    assign w_clr_err = CLR_ERR;
`endif

    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_q;
    logic             r_sdo;
    logic             r_err;

    logic [WIDTH-1:0] w_sr_shifted;
    logic             w_far_bit;
    logic             w_full;

    // Direction-dependent shift path and the bit that falls off the far end.
    generate
        if (MSB_FIRST == SHIFT_MSB_FIRST) begin : g_msb_first
            assign w_sr_shifted = {r_sr[WIDTH-2:0], w_sdi};
            assign w_far_bit    = r_sr[WIDTH-1];
        end else begin : g_lsb_first
            assign w_sr_shifted = {w_sdi, r_sr[WIDTH-1:1]};
            assign w_far_bit    = r_sr[0];
        end
    endgenerate

    assign w_full = (r_cnt == CNT_FULL);

    logic [WIDTH-1:0] w_sr_next;
    logic [CW-1:0]    w_cnt_next;
    logic [WIDTH-1:0] w_q_next;
    logic             w_sdo_next;
    logic             w_err_next;

    // Next-state for shift, count, latch and error; latch decisions use pre-edge count.
    always_comb begin
        w_sr_next  = r_sr;
        w_cnt_next = r_cnt;
        w_q_next   = r_q;
        w_sdo_next = r_sdo;
        w_err_next = r_err;

        if (w_shift) begin
            w_sr_next  = w_sr_shifted;
            w_sdo_next = w_far_bit;
            if (!w_full) begin
                w_cnt_next = r_cnt + CW'(1);
            end
        end

        if (w_clr_err) begin
            w_err_next = 1'b0;
        end

        if (w_latch) begin
            // A shift in the same cycle becomes the first bit of the next frame.
            w_cnt_next = w_shift ? CW'(1) : '0;
            if (w_full) begin
                w_q_next = r_sr;
            end else begin
                // Short frame: discard it and flag; setting wins over clearing.
                w_err_next = 1'b1;
            end
        end
    end

    // State registers, all cleared immediately by reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sr  <= '0;
            r_cnt <= '0;
            r_q   <= '0;
            r_sdo <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_sr  <= w_sr_next;
            r_cnt <= w_cnt_next;
            r_q   <= w_q_next;
            r_sdo <= w_sdo_next;
            r_err <= w_err_next;
        end
    end

    assign Q     = r_q;
    assign SDO   = r_sdo;
    assign READY = w_full;
    assign ERR   = r_err;

endmodule

// File: doc/led_shift_latch.md
# led_shift_latch

Parametrised serial-in/parallel-out shift register with a separate output latch stage. It is the successor to the single-bit D flip-flop used throughout the LED controller. It receives LED pattern bits serially from the host interface, counts them into a frame, and transfers a complete frame to the LED drive outputs on a latch strobe. It also provides daisy-chain output and short-frame error detection.

## Interface
Parameters:
- WIDTH, 8, number of LED channels and frame length in bits (2..32)
- MSB_FIRST, 1, 1: first shifted bit lands in Q[WIDTH-1]; 0: first bit lands in Q[0]

Ports (one clock; reset is asynchronous and active-high):
- CLK  input  1  system clock, all state on rising edge
- RST  input  1  asynchronous, active-high reset
- SDI  input  1  serial data in
- SHIFT  input  1  shift enable, sampled each cycle; one bit per cycle while high
- LATCH  input  1  latch strobe, level sampled each cycle
- CLR_ERR  input  1  clears ERR
- Q  output  WIDTH  latched LED pattern
- SDO  output  1  bit shifted out of the far end of the shift register, for daisy-chaining
- READY  output  1  high when the bit count has reached WIDTH
- ERR  output  1  sticky short-frame error

## Operation
- Internal state:
  - shift register sr[WIDTH-1:0]
  - bit counter cnt, width $clog2(WIDTH+1), range 0..WIDTH
  - output register Q
  - ERR flag
- Shift (SHIFT=1):
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], SDI}; SDO = sr[WIDTH-1] before the shift.
  - MSB_FIRST=0: sr <= {SDI, sr[WIDTH-1:1]}; SDO = sr[0] before the shift.
  - SDO is registered. It updates only on shift cycles and holds otherwise.
  - cnt increments and saturates at WIDTH. Shifts past WIDTH keep shifting; older bits exit on SDO.
- READY = (cnt == WIDTH), combinational from cnt.
- Latch (LATCH=1):
  - If cnt == WIDTH: Q <= sr (pre-edge value) and cnt <= 0.
  - If cnt < WIDTH: Q holds, ERR <= 1, and cnt <= 0 (the frame is discarded).
- Simultaneous SHIFT and LATCH:
  - The latch decision uses the pre-edge cnt.
  - Q takes the pre-edge sr.
  - The shift still occurs, and cnt <= 1.
- CLR_ERR=1: ERR <= 0, unless a short latch happens in the same cycle. Setting ERR has priority.
- sr is not cleared by latch. Only reset clears it.
- Reset values: sr=0, cnt=0, Q=0, SDO=0, READY=0, ERR=0.
- Reset asserted mid-frame immediately clears all state. Partial frames are lost.

## Timing
- Shift-to-count latency: READY rises on the edge that registers the WIDTH-th shift.
- Latch-to-output latency: 1 cycle. Q changes on the edge where LATCH is sampled high.
- ERR rises on the same edge as the offending LATCH.
- SDO lags SDI by WIDTH shift cycles.
- With LED_SHIFT_LATCH_SYNC_EN defined, add 2 cycles to all input-referred latencies. Relative timing between SDI, SHIFT, LATCH and CLR_ERR is preserved.

## Configuration
- Macro: LED_SHIFT_LATCH_SYNC_EN.
- Defined:
  - SDI, SHIFT, LATCH and CLR_ERR each pass through a two-flop synchronizer before use.
  - Synchronizer flops reset to 0.
  - Use this when the inputs come from an asynchronous host pin.
- Undefined:
  - Inputs are used directly; callers guarantee they are synchronous to CLK.
  - No synchronizer flops are instantiated.

## Structure
- Package led_ctrl_pkg holds:
  - LED_MAX_WIDTH = 32
  - cnt width function clog2_p1(WIDTH)
  - shift-direction constants SHIFT_MSB_FIRST / SHIFT_LSB_FIRST
- One sub-module: sync2 (single-bit two-flop synchronizer with async active-high reset). Instantiate it four times under the macro.

## Test plan
- Reset:
  - Stimulus: assert RST mid-shift with sr partially loaded.
  - Required: Q=0, READY=0, ERR=0 and SDO=0 immediately, with no clock edge needed.
- Full frame (WIDTH=8, MSB_FIRST=1):
  - Stimulus: shift 1,0,1,1,0,0,1,0, then LATCH.
  - Required: READY high after the 8th shift; Q=8'hB2 on the latch edge; READY low the next cycle.
- Short frame:
  - Stimulus: shift 5 bits, then LATCH.
  - Required: Q unchanged and ERR=1.
  - Then pulse CLR_ERR. Required: ERR=0.
- Overflow and daisy-chain:
  - Stimulus: shift 12 bits, with the first four being 1,1,0,1.
  - Required: SDO emits 1,1,0,1 on shifts 9..12; READY stays high; LATCH loads the last 8 bits.
- Simultaneous SHIFT and LATCH:
  - Stimulus: at cnt=8, assert both SHIFT and LATCH in one cycle.
  - Required: Q takes the pre-edge sr, cnt=1, ERR unchanged.
- MSB_FIRST=0 and macro variant:
  - Stimulus: the full-frame sequence above.
  - Required: Q=8'h4D.
  - With LED_SHIFT_LATCH_SYNC_EN defined, every response also arrives exactly 2 cycles later.
